// File: rtl/write_ptr_gen_if.sv
// Write-pointer generator bus: producer request, full flag from the controller,
// read-domain Gray pointer in, and the write-domain pointers/enables out.
interface write_ptr_gen_if #(
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  w_request_in;
  logic                  ctrl_full_in;
  logic [ADDR_WIDTH-1:0] r_gray_in;
  logic                  w_en_out;
  logic [ADDR_WIDTH-1:0] w_ptr_out;
  logic [ADDR_WIDTH-1:0] w_gray_out;
  logic [ADDR_WIDTH-1:0] r_ptr_sync_out;
  logic                  w_overflow_out;

  modport master (
    output w_request_in, ctrl_full_in, r_gray_in,
    input  w_en_out, w_ptr_out, w_gray_out, r_ptr_sync_out, w_overflow_out
  );

  modport slave (
    input  w_request_in, ctrl_full_in, r_gray_in,
    output w_en_out, w_ptr_out, w_gray_out, r_ptr_sync_out, w_overflow_out
  );
endinterface

// File: rtl/write_ptr_gen.sv
// Async-FIFO write-domain pointer generator: binary/Gray write pointer plus read-pointer
// synchronizer. Optional sticky overflow flag enabled by macro WPTR_OVERFLOW_FLAG_EN.
module write_ptr_gen #(
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             w_clk_in,
  input  logic             w_reset_n_in,
  write_ptr_gen_if.slave   bus
);

  logic                                   w_accept;
  logic [ADDR_WIDTH-1:0]                  r_ptr;
  logic [ADDR_WIDTH-1:0]                  r_gray;
  logic [ADDR_WIDTH-1:0]                  w_ptr_next;
  logic [ADDR_WIDTH-1:0]                  w_gray_next;
  logic [SYNC_STAGES-1:0][ADDR_WIDTH-1:0] r_sync;
  logic [ADDR_WIDTH-1:0]                  w_sync_last;
  logic [ADDR_WIDTH-1:0]                  w_sync_bin;

  // Writes are suppressed while reset is held so memory is never touched during reset.
  assign w_accept = bus.w_request_in & ~bus.ctrl_full_in & w_reset_n_in;

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_accept) begin
      w_ptr_next = r_ptr + ADDR_WIDTH'(1);
    end
    w_gray_next = w_ptr_next ^ (w_ptr_next >> 1);
  end

  // Gray copy is registered from the next binary value so both flops switch together.
  always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
    if (!w_reset_n_in) begin
      r_ptr  <= '0;
      r_gray <= '0;
    end else begin
      r_ptr  <= w_ptr_next;
      r_gray <= w_gray_next;
    end
  end

  always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
    if (!w_reset_n_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.r_gray_in};
    end
  end

  assign w_sync_last = r_sync[SYNC_STAGES-1];

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    w_sync_bin = '0;
    for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
      w_sync_bin[i] = ^(w_sync_last >> i);
    end
  end

`ifdef WPTR_OVERFLOW_FLAG_EN
  logic r_overflow;

  always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
    if (!w_reset_n_in) begin
      r_overflow <= 1'b0;
    end else if (bus.w_request_in && bus.ctrl_full_in) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.w_overflow_out = r_overflow;
`else
  assign bus.w_overflow_out = 1'b0;
`endif

  assign bus.w_en_out       = w_accept;
  assign bus.w_ptr_out      = r_ptr;
  assign bus.w_gray_out     = r_gray;
  assign bus.r_ptr_sync_out = w_sync_bin;

endmodule

// File: tb/tb_write_ptr_gen.sv
// Randomized self-checking bench for write_ptr_gen against a behavioural model
// (counter modulo depth, sticky overflow, delay queue for the synchronizer).
module tb_write_ptr_gen;
  localparam int unsigned AW   = 3;
  localparam int unsigned SS   = 2;
  localparam int unsigned MASK = (1 << AW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  write_ptr_gen_if #(.ADDR_WIDTH(AW)) bus ();

  write_ptr_gen #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(SS)
  ) dut (
    .w_clk_in    (clk),
    .w_reset_n_in(rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_ptr;
  bit          m_ovf;
  int unsigned m_hist[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned to_gray(input int unsigned b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  function automatic int unsigned from_gray(input int unsigned g);
    int unsigned b = 0;
    for (int s = 0; s < int'(AW); s++) b = b ^ (g >> s);
    return b & MASK;
  endfunction

  function automatic int unsigned exp_ovf();
`ifdef WPTR_OVERFLOW_FLAG_EN
    return m_ovf;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_ovf = 1'b0;
    m_hist = {};
    for (int i = 0; i < int'(SS); i++) m_hist.push_back(0);
  endtask

  task automatic check_outputs(input string where);
    check_val({where, ":ptr"},  bus.w_ptr_out,      m_ptr);
    check_val({where, ":gray"}, bus.w_gray_out,     to_gray(m_ptr));
    check_val({where, ":sync"}, bus.r_ptr_sync_out, from_gray(m_hist[SS-1]));
    check_val({where, ":ovf"},  bus.w_overflow_out, exp_ovf());
  endtask

  // Drive one cycle's inputs, check the write enable, clock, update model, check outputs.
  task automatic cycle(input logic req, input logic full, input int unsigned rg);
    bus.w_request_in = req;
    bus.ctrl_full_in = full;
    bus.r_gray_in    = rg[AW-1:0];
    #1;
    check_val("w_en", bus.w_en_out, req & ~full & rst_n);
    @(posedge clk);
    if (rst_n) begin
      if (req && !full) m_ptr = (m_ptr + 1) % (1 << AW);
      if (req && full)  m_ovf = 1'b1;
      m_hist.push_front(rg & MASK);
      void'(m_hist.pop_back());
    end
    #1;
    check_outputs("cyc");
  endtask

  int unsigned exp_gray[7] = '{1, 3, 2, 6, 7, 5, 4};
  int unsigned prev_gray;
  int unsigned rd;

  initial begin
    model_reset();
    bus.w_request_in = 1'b1;
    bus.ctrl_full_in = 1'b0;
    bus.r_gray_in    = '0;

    // Reset held with requests active
    repeat (3) cycle(1'b1, 1'b0, $urandom);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 0);
    check_val("idle_ptr", bus.w_ptr_out, 0);

    // Seven writes then wrap
    for (int i = 0; i < 7; i++) begin
      prev_gray = to_gray(m_ptr);
      cycle(1'b1, 1'b0, 0);
      check_val("dir_ptr",  bus.w_ptr_out, i + 1);
      check_val("dir_gray", bus.w_gray_out, exp_gray[i]);
      check_val("gray_step", $countones(prev_gray ^ bus.w_gray_out), 1);
    end
    cycle(1'b1, 1'b0, 0);
    check_val("wrap_ptr",  bus.w_ptr_out, 0);
    check_val("wrap_gray", bus.w_gray_out, 0);
    check_val("wrap_step", $countones(bus.w_gray_out ^ 3'b100), 1);

    // Requests while full are dropped
    repeat (4) cycle(1'b1, 1'b1, 0);
    check_val("full_ptr", bus.w_ptr_out, 0);
    cycle(1'b0, 1'b0, 0);
`ifdef WPTR_OVERFLOW_FLAG_EN
    check_val("ovf_sticky", bus.w_overflow_out, 1);
`else
    check_val("ovf_tied", bus.w_overflow_out, 0);
`endif

    // Synchronizer latency
    for (int k = 1; k <= int'(SS); k++) begin
      cycle(1'b0, 1'b0, 3'b011);
      check_val(k < int'(SS) ? "sync_early" : "sync_lat", bus.r_ptr_sync_out,
                k < int'(SS) ? 0 : 2);
    end
    for (int k = 1; k <= int'(SS); k++) begin
      cycle(1'b0, 1'b0, 3'b010);
      check_val(k < int'(SS) ? "sync_early2" : "sync_lat2", bus.r_ptr_sync_out,
                k < int'(SS) ? 2 : 3);
    end

    // Mid-clock reset during a burst at ptr 5
    repeat (5) cycle(1'b1, 1'b0, 3'b010);
    check_val("pre_rst_ptr", bus.w_ptr_out, 5);
    bus.w_request_in = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_ptr",  bus.w_ptr_out, 0);
    check_val("arst_gray", bus.w_gray_out, 0);
    check_val("arst_sync", bus.r_ptr_sync_out, 0);
    check_val("arst_ovf",  bus.w_overflow_out, 0);
    check_val("arst_en",   bus.w_en_out, 0);
    model_reset();
    cycle(1'b1, 1'b0, 0);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 0);
    check_val("post_rst_ptr", bus.w_ptr_out, 1);

    // Randomized traffic with a moving Gray read pointer
    rd = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) rd = (rd + 1) % (1 << AW);
      cycle(($urandom % 4) != 0, ($urandom % 4) == 0, to_gray(rd));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
